// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - sequencing front end for the multicycle radix-4 Booth multiplier core
//
// Accepts one RV64M multiply request, formats and holds the operands for the
// booth2_mul core, keeps the core's valid high for its whole iteration, then
// formats the 128-bit product and returns it over a valid/ready response.
// A kill while the core is counting drains the core before going idle.
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   req_valid_i / req_ready_o      request handshake
//   req_op_i                       000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 MULW, others MUL
//   req_rs1_i, req_rs2_i           64-bit operands
//   kill_i                         pipeline flush
//   resp_valid_o / resp_ready_i    response handshake
//   resp_data_o                    formatted 64-bit result
//   core_valid_o                   to core valid
//   core_rs1/2_sign_o              to core operand sign-extension bits
//   core_rs1/2_data_o              to core operand data
//   core_ready_i                   from core ready
//   core_result_i                  from core full 128-bit product

module mul_seq_ctrl (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic [2:0]   req_op_i,
   input  logic [63:0]  req_rs1_i,
   input  logic [63:0]  req_rs2_i,
   input  logic         kill_i,
   output logic         resp_valid_o,
   input  logic         resp_ready_i,
   output logic [63:0]  resp_data_o,
   output logic         core_valid_o,
   output logic         core_rs1_sign_o,
   output logic         core_rs2_sign_o,
   output logic [63:0]  core_rs1_data_o,
   output logic [63:0]  core_rs2_data_o,
   input  logic         core_ready_i,
   input  logic [127:0] core_result_i
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Result selection, decoded once at accept so the op code need not be kept.
   localparam logic [1:0] SEL_LO = 2'd0;
   localparam logic [1:0] SEL_HI = 2'd1;
   localparam logic [1:0] SEL_W  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [1:0]  sel_q, sel_d;
   logic [63:0] rs1_q, rs1_d;
   logic [63:0] rs2_q, rs2_d;
   logic        sign1_q, sign1_d;
   logic        sign2_q, sign2_d;
   logic [63:0] result_q, result_d;
   logic        load_ops;
   logic        load_res;

   // Operand formatting from the raw request.
   always_comb begin
      rs1_d   = req_rs1_i;
      rs2_d   = req_rs2_i;
      sign1_d = req_rs1_i[63];
      sign2_d = req_rs2_i[63];
      sel_d   = SEL_LO;
      case (req_op_i)
         3'b001: sel_d = SEL_HI;
         3'b010: begin
            sel_d   = SEL_HI;
            sign2_d = 1'b0;
         end
         3'b011: begin
            sel_d   = SEL_HI;
            sign1_d = 1'b0;
            sign2_d = 1'b0;
         end
         3'b100: begin
            // Word multiply: upper operand halves are don't-care.
            sel_d   = SEL_W;
            rs1_d   = {{32{req_rs1_i[31]}}, req_rs1_i[31:0]};
            rs2_d   = {{32{req_rs2_i[31]}}, req_rs2_i[31:0]};
            sign1_d = req_rs1_i[31];
            sign2_d = req_rs2_i[31];
         end
         default: sel_d = SEL_LO;
      endcase
   end

   // Result formatting from the core product.
   always_comb begin
      result_d = core_result_i[63:0];
      case (sel_q)
         SEL_HI:  result_d = core_result_i[127:64];
         SEL_W:   result_d = {{32{core_result_i[31]}}, core_result_i[31:0]};
         default: result_d = core_result_i[63:0];
      endcase
   end

   always_comb begin
      state_d  = state_q;
      load_ops = 1'b0;
      load_res = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid_i && !kill_i) begin
               state_d  = ST_BUSY;
               load_ops = 1'b1;
            end
         end
         ST_BUSY: begin
            if (core_ready_i) begin
               // Core finishes on this edge anyway, so a kill needs no drain.
               state_d  = kill_i ? ST_IDLE : ST_DONE;
               load_res = !kill_i;
            end else if (kill_i) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Keep valid high so the core's counter runs out and self-clears.
            if (core_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_DONE: begin
            if (kill_i || resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         sel_q    <= SEL_LO;
         rs1_q    <= 64'd0;
         rs2_q    <= 64'd0;
         sign1_q  <= 1'b0;
         sign2_q  <= 1'b0;
         result_q <= 64'd0;
      end else begin
         state_q <= state_d;
         if (load_ops) begin
            sel_q   <= sel_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            sign1_q <= sign1_d;
            sign2_q <= sign2_d;
         end
         if (load_res) begin
            result_q <= result_d;
         end
      end
   end

   assign req_ready_o     = (state_q == ST_IDLE);
   assign resp_valid_o    = (state_q == ST_DONE);
   assign resp_data_o     = result_q;
   assign core_valid_o    = (state_q == ST_BUSY) || (state_q == ST_DRAIN);
   assign core_rs1_sign_o = sign1_q;
   assign core_rs2_sign_o = sign2_q;
   assign core_rs1_data_o = rs1_q;
   assign core_rs2_data_o = rs2_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl with a booth2_mul timing model

module tb_mul_seq_ctrl;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic [2:0]   req_op;
   logic [63:0]  req_rs1;
   logic [63:0]  req_rs2;
   logic         kill;
   logic         resp_valid;
   logic         resp_ready;
   logic [63:0]  resp_data;
   logic         core_valid;
   logic         core_rs1_sign;
   logic         core_rs2_sign;
   logic [63:0]  core_rs1_data;
   logic [63:0]  core_rs2_data;
   logic         core_ready;
   logic [127:0] core_result;

   int chk_cnt  = 0;
   int pass_cnt = 0;
   int cyc      = 0;
   int t_acc    = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mul_seq_ctrl dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .req_valid_i     (req_valid),
      .req_ready_o     (req_ready),
      .req_op_i        (req_op),
      .req_rs1_i       (req_rs1),
      .req_rs2_i       (req_rs2),
      .kill_i          (kill),
      .resp_valid_o    (resp_valid),
      .resp_ready_i    (resp_ready),
      .resp_data_o     (resp_data),
      .core_valid_o    (core_valid),
      .core_rs1_sign_o (core_rs1_sign),
      .core_rs2_sign_o (core_rs2_sign),
      .core_rs1_data_o (core_rs1_data),
      .core_rs2_data_o (core_rs2_data),
      .core_ready_i    (core_ready),
      .core_result_i   (core_result)
   );

   // booth2_mul model: ready in the 34th cycle of valid, full signed-extended product.
   logic [5:0] core_cnt;
   always @(posedge clk) begin
      if (rst) core_cnt <= 6'd0;
      else if (core_valid) core_cnt <= (core_cnt == 6'd33) ? 6'd0 : core_cnt + 6'd1;
      else core_cnt <= 6'd0;
   end
   assign core_ready  = core_valid && (core_cnt == 6'd33);
   assign core_result = {{64{core_rs1_sign}}, core_rs1_data} * {{64{core_rs2_sign}}, core_rs2_data};

   // RV64M reference semantics.
   function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      logic [127:0] p;
      logic [63:0]  w;
      case (op)
         3'b001: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
         3'b010: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
         3'b011: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
         3'b100: begin w = {32'd0, a[31:0]} * {32'd0, b[31:0]}; return {{32{w[31]}}, w[31:0]}; end
         default: begin p = {64'd0, a} * {64'd0, b};            return p[63:0]; end
      endcase
   endfunction

   // Must be called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input bit push, input logic [63:0] exp);
      int n = 0;
      while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk_cnt++;
      if (req_ready !== 1'b1) $display("FAIL issue_ready: req_ready=%b required 1", req_ready);
      else pass_cnt++;
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
      t_acc = cyc;
      if (push) exp_q.push_back(exp);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Waits for resp_valid, pops scoreboard, checks data and 35-cycle latency.
   task automatic wait_resp(input string name);
      int n = 0;
      logic [63:0] exp;
      while (resp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk_cnt++;
      if (resp_valid !== 1'b1) begin
         $display("FAIL %s_timeout: resp_valid=%b required 1", name, resp_valid);
         return;
      end
      pass_cnt++;
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
      chk_cnt++;
      if (resp_data !== exp) $display("FAIL %s_data: got %h required %h", name, resp_data, exp);
      else pass_cnt++;
      chk_cnt++;
      if (cyc - t_acc != 35) $display("FAIL %s_latency: got %0d required 35", name, cyc - t_acc);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_rs1 = 64'd0; req_rs2 = 64'd0;
      kill = 1'b0; resp_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({req_ready, resp_valid, core_valid, core_rs1_sign, core_rs2_sign} !== 5'b10000)
         $display("FAIL reset_ctrl: got %b required 10000",
                  {req_ready, resp_valid, core_valid, core_rs1_sign, core_rs2_sign});
      else pass_cnt++;
      chk_cnt++;
      if ({resp_data, core_rs1_data, core_rs2_data} !== 192'd0)
         $display("FAIL reset_data: got %h %h %h required 0", resp_data, core_rs1_data, core_rs2_data);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_ops();
      logic [2:0]  ops [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b101};
      logic [63:0] as  [6] = '{64'd3, '1, '1, '1, 64'h1234_5678_7FFF_FFFF, 64'd11};
      logic [63:0] bs  [6] = '{64'hFFFF_FFFF_FFFF_FFFB, '1, '1, '1, 64'hDEAD_BEEF_0000_0002, 64'd13};
      logic [63:0] es  [6] = '{64'hFFFF_FFFF_FFFF_FFF1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd143};
      for (int i = 0; i < 6; i++) begin
         issue(ops[i], as[i], bs[i], 1'b1, es[i]);
         chk_cnt++;
         if (core_valid !== 1'b1) $display("FAIL op%0d_core_valid: got %b required 1", i, core_valid);
         else pass_cnt++;
         wait_resp($sformatf("op%0d", i));
         @(negedge clk);
         chk_cnt++;
         if (req_ready !== 1'b1 || resp_valid !== 1'b0 || core_valid !== 1'b0)
            $display("FAIL op%0d_idle_T36: rr=%b rv=%b cv=%b required 1 0 0", i, req_ready, resp_valid, core_valid);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      logic [2:0]  op;
      logic [63:0] a, b;
      for (int i = 0; i < 5; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = {$urandom, $urandom};
         b  = {$urandom, $urandom};
         prev = t_acc;
         issue(op, a, b, 1'b1, ref_mul(op, a, b));
         if (i > 0) begin
            chk_cnt++;
            if (t_acc - prev != 36) $display("FAIL b2b_period: got %0d required 36", t_acc - prev);
            else pass_cnt++;
         end
         wait_resp($sformatf("b2b%0d", i));
      end
      @(negedge clk);
   endtask

   task automatic test_kill();
      int bad = 0;
      issue(3'b000, 64'd5, 64'd9, 1'b0, 64'd0);
      while (cyc < t_acc + 10) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      while (cyc < t_acc + 34) begin
         if (core_valid !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      chk_cnt++;
      if (bad != 0) $display("FAIL kill_drain_hold: %0d bad cycles required 0", bad);
      else pass_cnt++;
      chk_cnt++;
      if (core_valid !== 1'b1 || core_ready !== 1'b1)
         $display("FAIL kill_T34: cv=%b cr=%b required 1 1", core_valid, core_ready);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (req_ready !== 1'b1 || core_valid !== 1'b0 || resp_valid !== 1'b0)
         $display("FAIL kill_T35: rr=%b cv=%b rv=%b required 1 0 0", req_ready, core_valid, resp_valid);
      else pass_cnt++;
      issue(3'b000, 64'd7, 64'd6, 1'b1, 64'd42);
      wait_resp("after_kill");
      @(negedge clk);

      // Kill coinciding with core_ready: straight to IDLE, nothing returned.
      issue(3'b000, 64'd2, 64'd2, 1'b0, 64'd0);
      while (cyc < t_acc + 34) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk_cnt++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || core_valid !== 1'b0)
         $display("FAIL kill_at_ready: rr=%b rv=%b cv=%b required 1 0 0", req_ready, resp_valid, core_valid);
      else pass_cnt++;

      // Request presented with kill is ignored.
      req_valid = 1'b1; kill = 1'b1; req_op = 3'b000; req_rs1 = 64'd1; req_rs2 = 64'd1;
      @(negedge clk);
      req_valid = 1'b0; kill = 1'b0;
      chk_cnt++;
      if (req_ready !== 1'b1 || core_valid !== 1'b0)
         $display("FAIL kill_req_ignored: rr=%b cv=%b required 1 0", req_ready, core_valid);
      else pass_cnt++;

      // Kill in DONE drops the result even with resp_ready high.
      resp_ready = 1'b0;
      issue(3'b000, 64'd1, 64'd1, 1'b1, 64'd1);
      wait_resp("kill_done");
      kill = 1'b1; resp_ready = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      chk_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL kill_done_idle: rv=%b rr=%b required 0 1", resp_valid, req_ready);
      else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int bad = 0;
      logic [63:0] d0;
      resp_ready = 1'b0;
      issue(3'b011, 64'hFFFF_0000_1234_5678, 64'h8000_0000_0000_0003, 1'b1,
            ref_mul(3'b011, 64'hFFFF_0000_1234_5678, 64'h8000_0000_0000_0003));
      wait_resp("bp");
      d0 = resp_data;
      repeat (20) begin
         @(negedge clk);
         if (resp_valid !== 1'b1 || resp_data !== d0 || req_ready !== 1'b0) bad++;
      end
      chk_cnt++;
      if (bad != 0) $display("FAIL bp_stable: %0d bad cycles required 0", bad);
      else pass_cnt++;
      resp_ready = 1'b1;
      @(negedge clk);
      chk_cnt++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL bp_release: rv=%b rr=%b required 0 1", resp_valid, req_ready);
      else pass_cnt++;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid !== 1'b0) bad++;
      end
      chk_cnt++;
      if (bad != 0) $display("FAIL bp_single_handshake: %0d extra resp cycles required 0", bad);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      issue(3'b001, '1, 64'd3, 1'b0, 64'd0);
      while (cyc < t_acc + 20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_cnt++;
      if ({req_ready, resp_valid, core_valid, core_rs1_sign, core_rs2_sign} !== 5'b10000)
         $display("FAIL midrst_ctrl: got %b required 10000",
                  {req_ready, resp_valid, core_valid, core_rs1_sign, core_rs2_sign});
      else pass_cnt++;
      chk_cnt++;
      if ({resp_data, core_rs1_data, core_rs2_data} !== 192'd0)
         $display("FAIL midrst_data: got %h %h %h required 0", resp_data, core_rs1_data, core_rs2_data);
      else pass_cnt++;
      issue(3'b011, 64'h8000_0000_0000_0000, 64'd4, 1'b1, 64'd2);
      wait_resp("midrst_mulhu");
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_kill();
      test_backpressure();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
